// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive-side and transmit-side FIFOs.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_ADDR_W = $clog2(UART_FIFO_DEPTH);

  typedef enum logic [1:0] {
    FIFO_IDLE   = 2'b00,
    FIFO_POP    = 2'b01,
    FIFO_PUSH   = 2'b10,
    FIFO_PUSHPOP = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for a strobe from another clock domain plus a one-cycle
// rising-edge pulse; also used for the transmitter's done strobe.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic prev_r;
  logic valid1_r;
  logic valid2_r;

  // Synchroniser chain; prev stays high until s2 carries a real post-reset sample,
  // so a strobe already high at reset release never looks like a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      prev_r   <= 1'b1;
      valid1_r <= 1'b0;
      valid2_r <= 1'b0;
    end else begin
      s1_r     <= din;
      s2_r     <= s1_r;
      prev_r   <= valid2_r ? s2_r : 1'b1;
      valid1_r <= 1'b1;
      valid2_r <= valid1_r;
    end
  end

  assign rise = s2_r & ~prev_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: pushes one byte per receiver strobe and presents the
// head entry first-word-fall-through to the peripheral bus.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_status,
  input  logic                   rd_en,
  input  logic                   clr_overrun,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rx_ready,
  output logic                   fifo_full,
  output logic                   overrun,
  output logic [ADDR_W:0]        count
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(32'd1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(32'd0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(32'd1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(32'd0);

  logic [UART_DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_r;
  logic [ADDR_W-1:0]      rd_ptr_r;
  logic [ADDR_W:0]        count_r;
  logic                   rx_ready_r;
  logic                   fifo_full_r;
  logic                   overrun_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   wr_en_s;
  logic                   drop_s;
  logic [ADDR_W:0]        count_next_s;
  fifo_op_e               op_s;

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx_status),
    .rise  (push_s)
  );

  assign pop_s = rd_en & rx_ready_r;
  assign op_s  = fifo_op_e'({push_s, pop_s});

  // Decide write enable, drop and next occupancy from the push/pop combination.
  always_comb begin
    wr_en_s      = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    case (op_s)
      FIFO_PUSH: begin
        if (!fifo_full_r) begin
          wr_en_s      = 1'b1;
          count_next_s = count_r + CNT_ONE;
        end else begin
          drop_s       = 1'b1;
        end
      end
      FIFO_POP: begin
        count_next_s = count_r - CNT_ONE;
      end
      FIFO_PUSHPOP: begin
        wr_en_s      = 1'b1;
        count_next_s = count_r;
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
  end

  // Storage array; contents need no reset because reads are gated by rx_ready.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // Pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      rx_ready_r  <= 1'b0;
      fifo_full_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      rx_ready_r  <= (count_next_s != CNT_ZERO);
      fifo_full_r <= (count_next_s == CNT_FULL);
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (clr_overrun) begin
      overrun_r <= 1'b0;
    end
  end

  assign rd_data   = rx_ready_r ? mem_r[rd_ptr_r] : {UART_DATA_W{1'b0}};
  assign rx_ready  = rx_ready_r;
  assign fifo_full = fifo_full_r;
  assign overrun   = overrun_r;
  assign count     = count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rx_ready;
  logic       fifo_full;
  logic       overrun;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_status   (rx_status),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .rx_ready    (rx_ready),
    .fifo_full   (fifo_full),
    .overrun     (overrun),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int len);
    rx_data   = b;
    rx_status = 1'b1;
    repeat (len) tick();
    rx_status = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_status = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_count", count, 5'd0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    repeat (3) tick();

    // 1: single strobe latency and pop
    rx_data = 8'hA5; rx_status = 1'b1;
    tick();
    chk("t1_lat_k", rx_ready, 1'b0);
    tick();
    chk("t1_lat_k1", rx_ready, 1'b0);
    tick();
    chk("t1_lat_k2", rx_ready, 1'b1);
    chk("t1_data", rd_data, 8'hA5);
    chk("t1_count", count, 5'd1);
    tick();
    rx_status = 1'b0;
    repeat (4) tick();
    chk("t1_once", count, 5'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t1_pop_count", count, 5'd0);
    chk("t1_pop_ready", rx_ready, 1'b0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 16; i++) strobe(8'(i), 4);
    chk("t2_full", fifo_full, 1'b1);
    chk("t2_count", count, 5'd16);
    chk("t2_ovr0", overrun, 1'b0);
    strobe(8'hEE, 4);
    chk("t2_ovr1", overrun, 1'b1);
    chk("t2_count_ovf", count, 5'd16);
    chk("t2_head_ovf", rd_data, 8'h00);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", rd_data, 32'(i));
      tick();
    end
    rd_en = 1'b0;
    chk("t2_empty", count, 5'd0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t2_clr", overrun, 1'b0);

    // 3: push coinciding with pop while full
    for (int i = 0; i < 16; i++) strobe(8'h10 + 8'(i), 4);
    chk("t3_full", count, 5'd16);
    rx_data = 8'h55; rx_status = 1'b1;
    repeat (2) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t3_count", count, 5'd16);
    chk("t3_ovr", overrun, 1'b0);
    chk("t3_head", rd_data, 8'h11);
    repeat (2) tick();
    rx_status = 1'b0;
    repeat (4) tick();
    chk("t3_count2", count, 5'd16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", rd_data, (i < 15) ? 32'(8'h11 + 8'(i)) : 32'h55);
      tick();
    end
    rd_en = 1'b0;

    // 4: pop requests on empty are ignored
    rd_en = 1'b1;
    repeat (10) tick();
    rd_en = 1'b0;
    chk("t4_count", count, 5'd0);
    chk("t4_ready", rx_ready, 1'b0);
    strobe(8'h3C, 4);
    chk("t4_data", rd_data, 8'h3C);
    chk("t4_count1", count, 5'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // 5: long strobe pushes once; overflow beats clear
    strobe(8'h77, 5);
    chk("t5_once", count, 5'd1);
    chk("t5_data", rd_data, 8'h77);
    for (int i = 0; i < 15; i++) strobe(8'h80 + 8'(i), 4);
    chk("t5_full", fifo_full, 1'b1);
    rx_data = 8'hDD; rx_status = 1'b1;
    repeat (2) tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t5_set_wins", overrun, 1'b1);
    repeat (2) tick();
    rx_status = 1'b0;
    repeat (4) tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("t5_clr", overrun, 1'b0);

    // 6: asynchronous reset mid-operation with strobe high
    rd_en = 1'b1;
    repeat (9) tick();
    rd_en = 1'b0;
    chk("t6_seven", count, 5'd7);
    chk("t6_head", rd_data, 8'h88);
    rx_data = 8'h99; rx_status = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_count", count, 5'd0);
    chk("t6_rst_ready", rx_ready, 1'b0);
    chk("t6_rst_full", fifo_full, 1'b0);
    chk("t6_rst_data", rd_data, 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_no_push", count, 5'd0);
    rx_status = 1'b0;
    repeat (4) tick();
    chk("t6_no_push2", rx_ready, 1'b0);
    strobe(8'hC3, 4);
    chk("t6_fresh_count", count, 5'd1);
    chk("t6_fresh_data", rd_data, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
